// File: rtl/sq_wave_gen.sv
// Square-wave / tick generator: counted or free-running periods, config via valid/ready, applied at period boundaries.
// Optional macro SQW_DUTY_EN adds cfg_low for an independent low-phase length (otherwise 50% duty).
module sq_wave_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half,
`ifdef SQW_DUTY_EN
    input  logic [CNT_W-1:0] cfg_low,
`endif
    input  logic [CNT_W-1:0] cfg_count,
    output logic             wave_out,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d, l_q, l_d, cnt_q, cnt_d, per_q, per_d, ph_q, ph_d;
    logic [CNT_W-1:0] sh_h_q, sh_h_d, sh_l_q, sh_l_d, sh_c_q, sh_c_d;
    logic             pend_q, pend_d;
    logic             wave_q, wave_d, tick_q, tick_d, busy_q, busy_d;
    logic             done_q, done_d, rdy_q, rdy_d;
    logic             accept;
    logic [CNT_W-1:0] new_half, new_low, per_inc;

    assign accept   = cfg_valid && rdy_q && en;
    assign new_half = clamp1(cfg_half);
`ifdef SQW_DUTY_EN
    assign new_low  = clamp1(cfg_low);
`else
    assign new_low  = new_half;
`endif
    assign per_inc  = sat_inc(per_q);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        l_d     = l_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        ph_d    = ph_q;
        pend_d  = pend_q;
        sh_h_d  = sh_h_q;
        sh_l_d  = sh_l_q;
        sh_c_d  = sh_c_q;
        wave_d  = 1'b0;
        tick_d  = 1'b0;
        done_d  = 1'b0;

        if (!en) begin
            state_d = S_IDLE;
            per_d   = '0;
            ph_d    = '0;
            pend_d  = 1'b0;
            sh_h_d  = '0;
            sh_l_d  = '0;
            sh_c_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = S_RUN;
                        h_d     = new_half;
                        l_d     = new_low;
                        cnt_d   = cfg_count;
                        per_d   = '0;
                        ph_d    = '0;
                        wave_d  = 1'b1;
                        tick_d  = 1'b1;
                    end
                end
                S_RUN: begin
                    wave_d = wave_q;
                    if (accept) begin
                        pend_d = 1'b1;
                        sh_h_d = new_half;
                        sh_l_d = new_low;
                        sh_c_d = cfg_count;
                    end
                    if (wave_q) begin
                        if (ph_q == h_q - CNT_W'(1)) begin
                            wave_d = 1'b0;
                            ph_d   = '0;
                        end else begin
                            ph_d = ph_q + CNT_W'(1);
                        end
                    end else if (ph_q == l_q - CNT_W'(1)) begin
                        // Period boundary: a pending or same-edge config beats run completion.
                        ph_d = '0;
                        if (pend_q || accept) begin
                            h_d    = pend_q ? sh_h_q : new_half;
                            l_d    = pend_q ? sh_l_q : new_low;
                            cnt_d  = pend_q ? sh_c_q : cfg_count;
                            per_d  = '0;
                            pend_d = 1'b0;
                            wave_d = 1'b1;
                            tick_d = 1'b1;
                        end else if (cnt_q != '0 && per_inc == cnt_q) begin
                            state_d = S_DONE;
                            per_d   = '0;
                            done_d  = 1'b1;
                            wave_d  = 1'b0;
                        end else begin
                            per_d  = per_inc;
                            wave_d = 1'b1;
                            tick_d = 1'b1;
                        end
                    end else begin
                        ph_d = ph_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    pend_d  = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_RUN);
        rdy_d  = en && ((state_d == S_IDLE) || (state_d == S_RUN && !pend_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            l_q     <= '0;
            cnt_q   <= '0;
            per_q   <= '0;
            ph_q    <= '0;
            sh_h_q  <= '0;
            sh_l_q  <= '0;
            sh_c_q  <= '0;
            pend_q  <= 1'b0;
            wave_q  <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            l_q     <= l_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            ph_q    <= ph_d;
            sh_h_q  <= sh_h_d;
            sh_l_q  <= sh_l_d;
            sh_c_q  <= sh_c_d;
            pend_q  <= pend_d;
            wave_q  <= wave_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    assign cfg_ready = rdy_q;
    assign wave_out  = wave_q;
    assign tick      = tick_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sq_wave_gen.sv
// Self-checking bench for sq_wave_gen; expected waveforms come from an arithmetic period model.
module tb_sq_wave_gen;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_half = '0;
    logic [CNT_W-1:0] cfg_count = '0;
`ifdef SQW_DUTY_EN
    logic [CNT_W-1:0] cfg_low = '0;
`endif
    logic             cfg_ready, wave_out, tick, busy, done;

    int checks = 0;
    int errors = 0;

    sq_wave_gen #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_half  (cfg_half),
`ifdef SQW_DUTY_EN
        .cfg_low   (cfg_low),
`endif
        .cfg_count (cfg_count),
        .wave_out  (wave_out),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {wave, tick, busy, done} k cycles after the accepting edge.
    function automatic logic [3:0] model(input int k, input int h, input int l, input int c);
        int p;
        int pos;
        p = h + l;
        if (c != 0 && k > c * p)
            return {1'b0, 1'b0, 1'b0, (k == c * p + 1)};
        pos = (k - 1) % p;
        return {(pos < h), (pos == 0), 1'b1, 1'b0};
    endfunction

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic start_run(input int h, input int c);
        int n;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready: cfg_ready=%b required 1 within 50 cycles", cfg_ready);
        end
        cfg_half  = CNT_W'(h);
        cfg_count = CNT_W'(c);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic stop_run();
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        int d;
        rst_n = 1'b0;
        #1;
        obs = {wave_out, tick, busy, done, cfg_ready};
        checks++;
        if (obs !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000", obs);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early: cfg_ready=%b required 0", cfg_ready);
        end
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: cfg_ready=%b required 1", cfg_ready);
        end
        // Async reset during a high phase of a running waveform.
        start_run(5, 0);
        d = $urandom_range(0, 4);
        repeat (d) @(negedge clk);
        checks++;
        if (wave_out !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun: wave_out=%b busy=%b required 1 1", wave_out, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = {wave_out, tick, busy, done, cfg_ready};
        checks++;
        if (obs !== 5'b0) begin
            errors++;
            $display("FAIL reset_midrun: got %b required 00000", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun_ready_early: cfg_ready=%b required 0", cfg_ready);
        end
        @(negedge clk);
        obs = {wave_out, tick, busy, done, cfg_ready};
        checks++;
        if (obs !== 5'b00001) begin
            errors++;
            $display("FAIL reset_midrun_idle: got %b required 00001", obs);
        end
    endtask

    task automatic test_counted(input int h, input int c, input int extra);
        logic [3:0] obs, exp;
        int he;
        he = eff(h);
        start_run(h, c);
        for (int k = 1; k <= c * 2 * he + extra; k++) begin
            obs = {wave_out, tick, busy, done};
            exp = model(k, he, he, c);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL counted h=%0d c=%0d k=%0d: {wave,tick,busy,done}=%b required %b", h, c, k, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_freerun();
        logic [3:0] obs, exp;
        start_run(0, 0);
        for (int k = 1; k <= 40; k++) begin
            obs = {wave_out, tick, busy, done};
            exp = model(k, 1, 1, 0);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL freerun k=%0d: {wave,tick,busy,done}=%b required %b", k, obs, exp);
            end
            @(negedge clk);
        end
        stop_run();
    endtask

    task automatic test_random();
        logic [3:0] obs, exp;
        int h, c, he, len;
        for (int it = 0; it < 6; it++) begin
            h  = $urandom_range(0, 6);
            c  = $urandom_range(0, 3);
            he = eff(h);
            len = (c == 0) ? 3 * 2 * he : c * 2 * he + 3;
            start_run(h, c);
            for (int k = 1; k <= len; k++) begin
                obs = {wave_out, tick, busy, done};
                exp = model(k, he, he, c);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL random h=%0d c=%0d k=%0d: {wave,tick,busy,done}=%b required %b", h, c, k, obs, exp);
                end
                @(negedge clk);
            end
            if (c == 0) stop_run();
        end
    endtask

    task automatic test_reconfig();
        logic [4:0] obs, exp;
        int j;
        start_run(4, 0);
        j = $urandom_range(1, 3);
        for (int k = 1; k <= 20; k++) begin
            obs = {wave_out, tick, busy, done, cfg_ready};
            exp[4:1] = (k <= 8) ? model(k, 4, 4, 0) : model(k - 8, 2, 2, 0);
            exp[0]   = (k <= j || k >= 9);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reconfig j=%0d k=%0d: {wave,tick,busy,done,ready}=%b required %b", j, k, obs, exp);
            end
            if (k == j) begin
                cfg_half  = CNT_W'(2);
                cfg_count = '0;
                cfg_valid = 1'b1;
            end else begin
                cfg_valid = 1'b0;
            end
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        stop_run();
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs, exp;
        start_run(2, 1);
        for (int k = 1; k <= 18; k++) begin
            obs = {wave_out, tick, busy, done};
            exp = (k <= 4) ? model(k, 2, 2, 1) : model(k - 4, 3, 3, 2);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL boundary_cfg k=%0d: {wave,tick,busy,done}=%b required %b", k, obs, exp);
            end
            if (k == 4) begin
                cfg_half  = CNT_W'(3);
                cfg_count = CNT_W'(2);
                cfg_valid = 1'b1;
            end else begin
                cfg_valid = 1'b0;
            end
            @(negedge clk);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_en_drop();
        logic [3:0] obs, exp;
        logic [4:0] o5;
        int h, p, q, kd;
        h  = $urandom_range(2, 6);
        p  = $urandom_range(0, 2);
        q  = $urandom_range(0, h - 1);
        kd = p * 2 * h + h + q + 1;
        start_run(h, 3);
        for (int k = 1; k <= kd; k++) begin
            obs = {wave_out, tick, busy, done};
            exp = model(k, h, h, 3);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL en_drop_run h=%0d k=%0d: {wave,tick,busy,done}=%b required %b", h, k, obs, exp);
            end
            if (k == kd) en = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            o5 = {wave_out, tick, busy, done, cfg_ready};
            checks++;
            if (o5 !== 5'b0) begin
                errors++;
                $display("FAIL en_drop_idle cycle=%0d: {wave,tick,busy,done,ready}=%b required 00000", k, o5);
            end
            @(negedge clk);
        end
        en = 1'b1;
        @(negedge clk);
        o5 = {wave_out, tick, busy, done, cfg_ready};
        checks++;
        if (o5 !== 5'b00001) begin
            errors++;
            $display("FAIL en_drop_resume: {wave,tick,busy,done,ready}=%b required 00001", o5);
        end
    endtask

    task automatic test_en_conflict();
        logic [2:0] obs;
        int n;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL conflict_ready: cfg_ready=%b required 1", cfg_ready);
        end
        en        = 1'b0;
        cfg_half  = CNT_W'(3);
        cfg_count = '0;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        en = 1'b1;
        obs = {wave_out, busy, cfg_ready};
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL conflict_drop: {wave,busy,ready}=%b required 000", obs);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            obs = {wave_out, busy, cfg_ready};
            checks++;
            if (obs !== 3'b001) begin
                errors++;
                $display("FAIL conflict_idle cycle=%0d: {wave,busy,ready}=%b required 001", k, obs);
            end
        end
    endtask

`ifdef SQW_DUTY_EN
    task automatic test_duty();
        logic [3:0] obs, exp;
        cfg_low = CNT_W'(5);
        start_run(3, 2);
        for (int k = 1; k <= 20; k++) begin
            obs = {wave_out, tick, busy, done};
            exp = model(k, 3, 5, 2);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL duty k=%0d: {wave,tick,busy,done}=%b required %b", k, obs, exp);
            end
            @(negedge clk);
        end
        cfg_low = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_counted(20, 3, 5);
        test_counted(0, 2, 3);
        test_freerun();
        test_random();
        test_reconfig();
        test_back_to_back();
        test_en_drop();
        test_en_conflict();
`ifdef SQW_DUTY_EN
        test_duty();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sq_wave_gen.md
Name: sq_wave_gen

Overview:
- Programmable square-wave and tick generator driven directly by the system clock `clk`. It turns the free-running clock into a lower-rate waveform plus a one-cycle tick.
- Downstream logic uses `wave_out` as a slow waveform and `tick` as a clock-enable. Nothing downstream runs on a derived clock.
- Runs either a fixed number of periods or free-runs. Configuration is written through a valid/ready handshake and takes effect at a period boundary.

Parameters:
- CNT_W, 16, width of the phase-length and period-count fields.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  run enable; deasserting it aborts any run
- cfg_valid  input  1  configuration request
- cfg_ready  output  1  configuration accepted when cfg_valid && cfg_ready
- cfg_half  input  CNT_W  high-phase length in clk cycles; 0 is treated as 1
- cfg_count  input  CNT_W  number of full periods to run; 0 means free-run
- wave_out  output  1  generated square wave, registered
- tick  output  1  one-cycle pulse on every rising edge of wave_out
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when a counted run completes

Behaviour:
- Reset: asynchronous and active-low; every register clears immediately.
  - Outputs during reset: wave_out=0, tick=0, busy=0, done=0, cfg_ready=0.
  - Internal state during reset: state=IDLE, all counters=0, no pending config.
  - cfg_ready rises 1 cycle after rst_n deasserts.
- States: IDLE, RUN, DONE.
- IDLE:
  - Outputs: cfg_ready=1 when en=1; wave_out=0; busy=0.
  - On handshake at edge N: latch H=max(cfg_half,1) and count. State is RUN at N+1, with wave_out=1 and tick=1 in that cycle.
- RUN, waveform:
  - wave_out is high for H cycles, then low for L cycles. L=H unless the optional feature is enabled.
  - Period counter increments on the last low cycle.
- RUN, counted run: when count!=0 and the period counter reaches count, go to DONE.
- RUN, pending config:
  - cfg_ready=1 only while no pending config is held.
  - An accepted config goes into a shadow register.
  - At the end of the current period it replaces H/L/count, the period counter clears, and the pending flag clears. The waveform stays continuous; the next cycle starts a high phase with tick=1.
- DONE:
  - 1 cycle with done=1, wave_out=0, busy=0, cfg_ready=0.
  - Then IDLE. Any pending config is discarded.
- en deasserted:
  - Any state goes to IDLE on the next edge, with wave_out=0.
  - Counters and pending config are cleared. No done pulse.
  - Handshakes are refused while en=0.
- Same-edge conflicts:
  - Handshake on the same edge as the final period boundary in a counted run: the period boundary applies the new config (no DONE), because a pending config wins.
  - en=0 on the same edge as a handshake: en=0 wins and the config is dropped.
- Counter width:
  - Phase counters are CNT_W bits and compare against H-1 / L-1, so no overflow is possible.
  - The period counter saturates at all-ones in free-run.
- Output timing: all outputs are registered; there is no combinational path from input to output.

Optional Feature:
- Macro: SQW_DUTY_EN.
- Defined:
  - Adds input `cfg_low` (CNT_W) for the low-phase length. L=max(cfg_low,1); it is shadowed and applied like cfg_half.
  - Allows any duty cycle.
- Undefined:
  - No cfg_low port.
  - L=H, so the duty cycle is always 50%.

Test Plan:
- Reset mid-RUN (rst_n low at an arbitrary cycle) -> all outputs 0 in the same timestep; after release, IDLE with cfg_ready=1 one cycle later.
- en=1, cfg_half=20, cfg_count=3:
  - wave_out period 40 cycles, high 20 / low 20.
  - tick at N+1, N+41, N+81.
  - done single pulse at N+121; busy falls with done; wave_out 0 thereafter.
- cfg_half=0, cfg_count=0 -> free-run toggling every cycle (period 2), tick every 2 cycles, done never asserts.
- Free-run with H=4; new cfg_half=2 accepted mid-high-phase:
  - cfg_ready=0 until the period ends.
  - Period ends on time at 8 cycles, then the period becomes 4.
- en dropped during the low phase of a 3-period run -> wave_out=0 next cycle, no done, IDLE.
- SQW_DUTY_EN defined, cfg_half=3, cfg_low=5, cfg_count=2 -> high 3 / low 5 twice; ticks 8 cycles apart; done at N+17.
